// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch stage with imem handshake, flush discard, one-entry skid and BTB prediction
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'hAAAAA000,
    parameter int          BTB_ENTRIES = 16,
    parameter bit          PRED_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fifo_full,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        enq,
    output logic [31:0] enq_pc,
    output logic [31:0] enq_instr,
    output logic        enq_pred_taken,
    output logic [31:0] enq_pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        stalling_if
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = 30 - IDX;
    localparam logic [1:0] FETCH = 2'd0, HOLD = 2'd1, DISCARD = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [31:0]            pc_q, pc_d, req_q, skid_instr_q, skid_target_q;
    logic                   skid_taken_q;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TW-1:0]          tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0] idx, upd_idx;
    logic           hit, upd_hit, pred_taken, fetch, hold, disc, capture, unused_upd;
    logic [31:0]    pred_next;
    logic [1:0]     upd_ctr;

    assign idx        = pc_q[IDX+1:2];
    assign hit        = valid_q[idx] && tag_q[idx] == pc_q[31:IDX+2];
    assign pred_taken = PRED_EN && hit && ctr_q[idx][1];
    assign pred_next  = pred_taken ? target_q[idx] : pc_q + 32'd4;

    assign upd_idx    = upd_pc[IDX+1:2];
    assign upd_hit    = valid_q[upd_idx] && tag_q[upd_idx] == upd_pc[31:IDX+2];
    assign upd_ctr    = upd_taken ? (ctr_q[upd_idx] == 2'd3 ? 2'd3 : ctr_q[upd_idx] + 2'd1)
                                  : (ctr_q[upd_idx] == 2'd0 ? 2'd0 : ctr_q[upd_idx] - 2'd1);
    assign unused_upd = ^upd_pc[1:0];

    always_comb begin
        fetch           = !rst && state_q == FETCH;
        hold            = !rst && state_q == HOLD;
        disc            = !rst && state_q == DISCARD;
        imem_rmask      = (fetch || disc) ? 4'hF : 4'h0;
        // DISCARD keeps presenting the abandoned request while pc already holds the redirect
        imem_addr       = rst ? RESET_PC : disc ? req_q : pc_q;
        enq             = !flush && !fifo_full && ((fetch && imem_resp) || hold);
        capture         = fetch && imem_resp && !flush && fifo_full;
        enq_pc          = pc_q;
        enq_instr       = hold ? skid_instr_q : imem_rdata;
        enq_pred_taken  = hold ? skid_taken_q : pred_taken;
        enq_pred_target = hold ? skid_target_q : pred_next;
        stalling_if     = !enq;
        state_d         = flush ? ((disc || (fetch && !imem_resp)) ? DISCARD : FETCH)
                        : capture ? HOLD
                        : ((hold && fifo_full) || (disc && !imem_resp)) ? state_q : FETCH;
        pc_d            = flush ? flush_pc : enq ? enq_pred_target : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fetch) req_q <= pc_q;
            if (capture) begin
                skid_instr_q  <= imem_rdata;
                skid_taken_q  <= pred_taken;
                skid_target_q <= pred_next;
            end
            if (upd_valid && (upd_hit || upd_taken)) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_pc[31:IDX+2];
                ctr_q[upd_idx]   <= upd_hit ? upd_ctr : 2'b10;
                if (upd_taken) target_q[upd_idx] <= upd_target;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus on PRED_EN=1 and PRED_EN=0 fetch units against a behavioural model
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'hAAAAA000;
    localparam int          N   = 16;
    localparam logic [31:0] K   = 32'h5A5A0F0F;

    logic clk = 0, rst, flush, fifo_full, upd_valid, upd_taken;
    logic [31:0] flush_pc, upd_pc, upd_target;
    logic [31:0] addr [2], rdata [2], e_pc [2], e_instr [2], e_tgt [2];
    logic [3:0]  rmask [2];
    logic        resp [2], enq [2], e_tk [2], stall [2];
    int          age [2];
    int          lat, checks = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .BTB_ENTRIES(N), .PRED_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .fifo_full(fifo_full),
        .imem_addr(addr[0]), .imem_rmask(rmask[0]), .imem_rdata(rdata[0]), .imem_resp(resp[0]),
        .enq(enq[0]), .enq_pc(e_pc[0]), .enq_instr(e_instr[0]), .enq_pred_taken(e_tk[0]),
        .enq_pred_target(e_tgt[0]), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .stalling_if(stall[0]));

    fetch_unit #(.RESET_PC(RPC), .BTB_ENTRIES(N), .PRED_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .fifo_full(fifo_full),
        .imem_addr(addr[1]), .imem_rmask(rmask[1]), .imem_rdata(rdata[1]), .imem_resp(resp[1]),
        .enq(enq[1]), .enq_pc(e_pc[1]), .enq_instr(e_instr[1]), .enq_pred_taken(e_tk[1]),
        .enq_pred_target(e_tgt[1]), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .stalling_if(stall[1]));

    // memory: answers a request once it has been presented for lat cycles
    assign resp[0]  = !rst && rmask[0] == 4'hF && age[0] >= lat;
    assign resp[1]  = !rst && rmask[1] == 4'hF && age[1] >= lat;
    assign rdata[0] = resp[0] ? addr[0] ^ K : 32'h0;
    assign rdata[1] = resp[1] ? addr[1] ^ K : 32'h0;

    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            age[d] <= (rst || rmask[d] != 4'hF || resp[d]) ? 0 : age[d] + 1;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    ent_t        mb [2][N];
    logic [31:0] m_pc [2], m_old [2], sk_instr [2], sk_tgt [2];
    bit          m_hold [2], m_stale [2], sk_tk [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void look(input int d, input logic [31:0] p, output bit tk, output logic [31:0] nx);
        int i = int'((p >> 2) % N);
        tk = (d == 0) && mb[d][i].v && mb[d][i].pc[31:2] == p[31:2] && mb[d][i].ctr >= 2;
        nx = tk ? mb[d][i].tgt : p + 32'd4;
    endfunction

    task automatic model_cycle(input int d);
        bit          tk, x_tk, x_enq;
        logic [31:0] nx, x_tgt;
        int          i;
        string       s = $sformatf("u%0d.", d);
        look(d, m_pc[d], tk, nx);
        x_tk  = m_hold[d] ? sk_tk[d] : tk;
        x_tgt = m_hold[d] ? sk_tgt[d] : nx;
        x_enq = !rst && !flush && !fifo_full && (m_hold[d] || (!m_stale[d] && resp[d]));
        chk({s, "rmask"}, {28'h0, rmask[d]}, (rst || m_hold[d]) ? 32'h0 : 32'hF);
        chk({s, "addr"}, addr[d], rst ? RPC : m_stale[d] ? m_old[d] : m_pc[d]);
        chk({s, "enq"}, {31'h0, enq[d]}, {31'h0, x_enq});
        chk({s, "stall"}, {31'h0, stall[d]}, {31'h0, !x_enq});
        if (x_enq) begin
            chk({s, "enq_pc"}, e_pc[d], m_pc[d]);
            chk({s, "enq_instr"}, e_instr[d], m_hold[d] ? sk_instr[d] : rdata[d]);
            chk({s, "pred_taken"}, {31'h0, e_tk[d]}, {31'h0, x_tk});
            chk({s, "pred_target"}, e_tgt[d], x_tgt);
        end
        if (rst) begin
            m_pc[d] = RPC; m_hold[d] = 0; m_stale[d] = 0;
            for (int j = 0; j < N; j++) mb[d][j].v = 0;
        end else begin
            if (flush) begin
                if (m_hold[d]) m_hold[d] = 0;
                else if (!m_stale[d] && !resp[d]) begin m_stale[d] = 1; m_old[d] = m_pc[d]; end
                m_pc[d] = flush_pc;
            end else if (m_hold[d]) begin
                if (!fifo_full) begin m_hold[d] = 0; m_pc[d] = sk_tgt[d]; end
            end else if (m_stale[d]) begin
                if (resp[d]) m_stale[d] = 0;
            end else if (resp[d]) begin
                if (fifo_full) begin
                    m_hold[d] = 1; sk_instr[d] = rdata[d]; sk_tk[d] = tk; sk_tgt[d] = nx;
                end else m_pc[d] = nx;
            end
            if (upd_valid) begin
                i = int'((upd_pc >> 2) % N);
                if (mb[d][i].v && mb[d][i].pc[31:2] == upd_pc[31:2]) begin
                    mb[d][i].ctr = upd_taken ? (mb[d][i].ctr == 3 ? 3 : mb[d][i].ctr + 1)
                                             : (mb[d][i].ctr == 0 ? 0 : mb[d][i].ctr - 1);
                    if (upd_taken) mb[d][i].tgt = upd_target;
                end else if (upd_taken) mb[d][i] = '{1'b1, upd_pc, upd_target, 2};
            end
        end
    endtask

    always @(negedge clk) begin
        #3;
        model_cycle(0);
        model_cycle(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input logic [31:0] a);
        int n = 0;
        while (!(rmask[0] == 4'hF && addr[0] == a && resp[0]) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL wait_resp %h: no response within 20 cycles", a);
        end
    endtask

    task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tg);
        step();
        upd_valid = 1; upd_pc = p; upd_taken = t; upd_target = tg;
        step();
        upd_valid = 0;
    endtask

    task automatic redirect(input logic [31:0] a);
        step();
        flush = 1; flush_pc = a;
        step();
        flush = 0;
    endtask

    initial begin
        rst = 1; flush = 0; flush_pc = 0; fifo_full = 0; lat = 1;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_rmask", {28'h0, rmask[0]}, 32'h0);
        chk("rst_addr", addr[0], RPC);
        chk("rst_enq", {31'h0, enq[0]}, 32'h0);
        chk("rst_stall", {31'h0, stall[0]}, 32'h1);
        rst = 0;
        // sequential fetch, empty BTB
        wait_resp(32'hAAAAA000); #1;
        chk("t1_enq", {31'h0, enq[0]}, 32'h1);
        chk("t1_pc", e_pc[0], 32'hAAAAA000);
        chk("t1_instr", e_instr[0], 32'hAAAAA000 ^ K);
        chk("t1_ptk", {31'h0, e_tk[0]}, 32'h0);
        step(); #1;
        chk("t1_addr2", addr[0], 32'hAAAAA004);
        // back-pressure into skid, released 3 cycles later
        wait_resp(32'hAAAAA004);
        fifo_full = 1; #1;
        chk("t2_noenq", {31'h0, enq[0]}, 32'h0);
        step(); #1;
        chk("t2_hold_rmask1", {28'h0, rmask[0]}, 32'h0);
        step(); #1;
        chk("t2_hold_rmask2", {28'h0, rmask[0]}, 32'h0);
        step();
        fifo_full = 0; lat = 3; #1;
        chk("t2_rel_enq", {31'h0, enq[0]}, 32'h1);
        chk("t2_rel_pc", e_pc[0], 32'hAAAAA004);
        chk("t2_rel_instr", e_instr[0], 32'hAAAAA004 ^ K);
        step(); #1;
        chk("t2_next", addr[0], 32'hAAAAA008);
        // flush while a 3-cycle request is outstanding
        step();
        flush = 1; flush_pc = 32'h1000; #1;
        chk("t3_flush_enq", {31'h0, enq[0]}, 32'h0);
        step();
        flush = 0; #1;
        chk("t3_disc_addr", addr[0], 32'hAAAAA008);
        chk("t3_disc_rmask", {28'h0, rmask[0]}, 32'hF);
        wait_resp(32'hAAAAA008); #1;
        chk("t3_drop", {31'h0, enq[0]}, 32'h0);
        step();
        lat = 1; #1;
        chk("t3_target", addr[0], 32'h1000);
        // flush coincident with a response
        wait_resp(32'h1000);
        flush = 1; flush_pc = 32'h3000; #1;
        chk("t4_enq", {31'h0, enq[0]}, 32'h0);
        step();
        flush = 0; #1;
        chk("t4_addr", addr[0], 32'h3000);
        wait_resp(32'h3000); #1;
        chk("t4_enq_pc", e_pc[0], 32'h3000);
        // BTB training and prediction
        upd(32'h1000, 1, 32'h2000);
        redirect(32'h1000);
        wait_resp(32'h1000); #1;
        chk("t5_ptk", {31'h0, e_tk[0]}, 32'h1);
        chk("t5_ptgt", e_tgt[0], 32'h2000);
        chk("t5_u1_ptk", {31'h0, e_tk[1]}, 32'h0);
        chk("t5_u1_ptgt", e_tgt[1], 32'h1004);
        step(); #1;
        chk("t5_next", addr[0], 32'h2000);
        chk("t5_u1_next", addr[1], 32'h1004);
        upd(32'h1000, 0, 32'h0);
        upd(32'h1000, 0, 32'h0);
        redirect(32'h1000);
        wait_resp(32'h1000); #1;
        chk("t6_ptk", {31'h0, e_tk[0]}, 32'h0);
        chk("t6_ptgt", e_tgt[0], 32'h1004);
        upd(32'h1000, 1, 32'h2000);
        upd(32'h1000, 1, 32'h2000);
        redirect(32'h1040);
        wait_resp(32'h1040); #1;
        chk("t7_alias_ptk", {31'h0, e_tk[0]}, 32'h0);
        chk("t7_alias_ptgt", e_tgt[0], 32'h1044);
        redirect(32'h1000);
        wait_resp(32'h1000); #1;
        chk("t7_retrain_ptgt", e_tgt[0], 32'h2000);
        chk("t8_u1_ptk", {31'h0, e_tk[1]}, 32'h0);
        chk("t8_u1_ptgt", e_tgt[1], 32'h1004);
        // flush while holding a skid entry
        wait_resp(32'h2000);
        fifo_full = 1;
        step();
        flush = 1; flush_pc = 32'h4000; fifo_full = 0; #1;
        chk("t9_hold_flush_enq", {31'h0, enq[0]}, 32'h0);
        step();
        flush = 0; #1;
        chk("t9_addr", addr[0], 32'h4000);
        chk("t9_rmask", {28'h0, rmask[0]}, 32'hF);
        // reset in the middle of a request
        step();
        rst = 1; #1;
        chk("t10_rst_rmask", {28'h0, rmask[0]}, 32'h0);
        step();
        rst = 0; #1;
        chk("t10_addr", addr[0], RPC);
        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
